uart_frame_tx: RTL and testbench

Parametrised serial frame transmitter with an input FIFO and CTS flow control. It generalises the fixed 8N1 frame driver used by the SoC bench into a synthesizable block. Data width, FIFO depth and divider width are set by parameters; parity and stop-bit count are selected at run time. It sits beside the APB UART as the second-generation TX path and is also instantiated in benches to drive RXDx pins of the DUT.

---
 rtl/uart_frame_tx_if.sv | 14 +
 rtl/uart_frame_tx.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_tx_if.sv
// uart_frame_tx_if: write handshake into the TX FIFO of uart_frame_tx.
//   wr_valid  producer -> FIFO  write request
//   wr_data   producer -> FIFO  word to send (DATA_W bits)
//   wr_ready  FIFO -> producer  FIFO can accept (registered !full)
interface uart_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: parametrised serial frame transmitter with TX FIFO and CTS
// flow control. Frame = start bit, DATA_W data bits LSB first, optional
// parity bit, one or two stop bits. Bit time is baud_div+1 HCLK cycles.
//
// Ports:
//   HCLK, HRESET        clock, asynchronous active-high reset
//   baud_div            HCLK cycles per bit minus 1 (latched per frame)
//   parity_en/_odd      parity enable / odd select (latched per frame)
//   two_stop            two stop bits when set (latched per frame)
//   wr (slave modport)  wr_valid / wr_data / wr_ready FIFO write port
//   cts                 async clear-to-send from the peer
//   txd                 serial output, idle high
//   tx_en               high for every cycle of a frame
//   busy                FIFO non-empty or frame in progress
//   fifo_level          occupied FIFO entries
module uart_frame_tx #(
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 4,
  parameter  int DIV_W      = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             two_stop,
  uart_frame_tx_if.slave   wr,
  input  logic             cts,
  output logic             txd,
  output logic             tx_en,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // FIFO state
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full_q, full_d;

  // CTS synchroniser
  logic cts_meta_q, cts_meta_d, cts_s_q, cts_s_d;

  // Frame engine
  state_e            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              pen_q, pen_d;
  logic              pbit_q, pbit_d;
  logic              two_q, two_d;
  logic              txd_q, txd_d;
  logic              tx_en_q, tx_en_d;

  logic [DATA_W-1:0] head;
  logic              push, pop, load, start_ok, bit_end;

  assign head = mem_q[rptr_q];

  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    full_d     = full_q;
    cts_meta_d = cts;
    cts_s_d    = cts_meta_q;
    state_d    = state_q;
    sh_d       = sh_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    pen_d      = pen_q;
    pbit_d     = pbit_q;
    two_d      = two_q;
    txd_d      = txd_q;
    tx_en_d    = tx_en_q;
    pop        = 1'b0;
    load       = 1'b0;

    // Writes while full are dropped even if a pop frees a slot this cycle.
    push     = wr.wr_valid && !full_q;
    start_ok = (level_q != '0) && cts_s_q;
    bit_end  = (cnt_q == div_q);

    // Bit timer runs for every non-idle state and wraps at each bit boundary.
    if (state_q != IDLE)
      cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start_ok) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          txd_d   = sh_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            bit_d = '0;
            if (pen_q) begin
              state_d = PARITY;
              txd_d   = pbit_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
            sh_d  = sh_q >> 1;
            txd_d = sh_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (two_q && (bit_q == '0)) begin
            bit_d = BIT_W'(1);
          end else if (start_ok) begin
            // Next frame starts on the very next cycle: no idle gap.
            load = 1'b1;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
            tx_en_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        tx_en_d = 1'b0;
      end
    endcase

    // Frame load: pop head word and freeze per-frame configuration.
    if (load) begin
      pop     = 1'b1;
      state_d = START;
      sh_d    = head;
      div_d   = baud_div;
      pen_d   = parity_en;
      pbit_d  = (^head) ^ parity_odd;
      two_d   = two_stop;
      cnt_d   = '0;
      bit_d   = '0;
      txd_d   = 1'b0;
      tx_en_d = 1'b1;
    end

    if (push) begin
      mem_d[wptr_q] = wr.wr_data;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (pop) rptr_d = rptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    full_d  = (level_d == LVL_W'(FIFO_DEPTH));
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      cts_meta_q <= 1'b0;
      cts_s_q    <= 1'b0;
      state_q    <= IDLE;
      sh_q       <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      pen_q      <= 1'b0;
      pbit_q     <= 1'b0;
      two_q      <= 1'b0;
      txd_q      <= 1'b1;
      tx_en_q    <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      cts_meta_q <= cts_meta_d;
      cts_s_q    <= cts_s_d;
      state_q    <= state_d;
      sh_q       <= sh_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      pen_q      <= pen_d;
      pbit_q     <= pbit_d;
      two_q      <= two_d;
      txd_q      <= txd_d;
      tx_en_q    <= tx_en_d;
    end
  end

  assign txd         = txd_q;
  assign tx_en       = tx_en_q;
  assign busy        = (state_q != IDLE) || (level_q != '0);
  assign fifo_level  = level_q;
  assign wr.wr_ready = !full_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
module tb_uart_frame_tx;
  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [15:0] baud_div, baud_div9;
  logic        parity_en, parity_odd, two_stop, cts;
  logic        txd8, tx_en8, busy8, txd9, tx_en9, busy9;
  logic [2:0]  lvl8, lvl9;

  always #5 HCLK = ~HCLK;

  uart_frame_tx_if #(.DATA_W(8)) w8 ();
  uart_frame_tx_if #(.DATA_W(9)) w9 ();

  uart_frame_tx #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(16)) dut8 (
    .HCLK(HCLK), .HRESET(HRESET), .baud_div(baud_div), .parity_en(parity_en),
    .parity_odd(parity_odd), .two_stop(two_stop), .wr(w8), .cts(cts),
    .txd(txd8), .tx_en(tx_en8), .busy(busy8), .fifo_level(lvl8));

  uart_frame_tx #(.DATA_W(9), .FIFO_DEPTH(4), .DIV_W(16)) dut9 (
    .HCLK(HCLK), .HRESET(HRESET), .baud_div(baud_div9), .parity_en(parity_en),
    .parity_odd(parity_odd), .two_stop(two_stop), .wr(w9), .cts(cts),
    .txd(txd9), .tx_en(tx_en9), .busy(busy9), .fifo_level(lvl9));

  int   total = 0;
  int   bad   = 0;
  logic sel9  = 1'b0;
  logic obs_txd, obs_en;
  assign obs_txd = sel9 ? txd9 : txd8;
  assign obs_en  = sel9 ? tx_en9 : tx_en8;

  logic log_txd [0:255];
  logic log_en  [0:255];
  logic exp_txd [0:255];
  logic exp_en  [0:255];
  int   exp_len;

  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  task automatic capture(input int off, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      log_txd[off+i] = obs_txd;
      log_en[off+i]  = obs_en;
    end
  endtask

  task automatic add_frame(input logic [8:0] d, input int nd, input int pbit,
                           input int nstop, input int cyc);
    logic [8:0] dv;
    dv = d;
    for (int c = 0; c < cyc; c++) begin exp_txd[exp_len] = 1'b0; exp_en[exp_len] = 1'b1; exp_len++; end
    for (int k = 0; k < nd; k++)
      for (int c = 0; c < cyc; c++) begin exp_txd[exp_len] = dv[k]; exp_en[exp_len] = 1'b1; exp_len++; end
    if (pbit >= 0)
      for (int c = 0; c < cyc; c++) begin exp_txd[exp_len] = (pbit != 0); exp_en[exp_len] = 1'b1; exp_len++; end
    for (int c = 0; c < cyc * nstop; c++) begin exp_txd[exp_len] = 1'b1; exp_en[exp_len] = 1'b1; exp_len++; end
  endtask

  task automatic add_idle(input int n);
    for (int c = 0; c < n; c++) begin exp_txd[exp_len] = 1'b1; exp_en[exp_len] = 1'b0; exp_len++; end
  endtask

  task automatic do_reset();
    w8.wr_valid = 1'b0; w9.wr_valid = 1'b0;
    HRESET = 1'b1;
    tick(); tick();
    HRESET = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic write8(input logic [7:0] d);
    w8.wr_valid = 1'b1; w8.wr_data = d;
    tick();
    w8.wr_valid = 1'b0;
  endtask

  // Waits for the first start-bit sample and stores it as log index 0.
  task automatic wait_start(input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (obs_txd === 1'b0) begin
        log_txd[0] = obs_txd; log_en[0] = obs_en; found = 1;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s start_timeout got=no_start want=start_within_40", name);
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    #3;
    total++; if (txd8 !== 1'b1)  begin bad++; $display("FAIL reset_txd got=%b want=1", txd8); end
    total++; if (tx_en8 !== 1'b0) begin bad++; $display("FAIL reset_tx_en got=%b want=0", tx_en8); end
    total++; if (w8.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b want=1", w8.wr_ready); end
    total++; if (lvl8 !== 3'd0)  begin bad++; $display("FAIL reset_level got=%0d want=0", lvl8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy8); end
    do_reset();
  endtask

  task automatic test_8n1();
    do_reset();
    baud_div = 16'd3; parity_en = 0; parity_odd = 0; two_stop = 0; cts = 1;
    write8(8'hA5);
    total++; if (txd8 !== 1'b1) begin bad++; $display("FAIL 8n1_latency_idle got=%b want=1", txd8); end
    total++; if (lvl8 !== 3'd1) begin bad++; $display("FAIL 8n1_level got=%0d want=1", lvl8); end
    capture(0, 42);
    exp_len = 0; add_frame(9'h0A5, 8, -1, 1, 4); add_idle(2);
    for (int i = 0; i < exp_len; i++) begin
      total++;
      if (log_txd[i] !== exp_txd[i] || log_en[i] !== exp_en[i]) begin
        bad++; $display("FAIL 8n1_cycle%0d got=txd%b/en%b want=txd%b/en%b", i, log_txd[i], log_en[i], exp_txd[i], exp_en[i]);
      end
    end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL 8n1_busy_after got=%b want=0", busy8); end
  endtask

  task automatic test_parity();
    // even parity, two stop bits: 0xA5 has four ones -> parity 0
    do_reset();
    baud_div = 16'd3; parity_en = 1; parity_odd = 0; two_stop = 1; cts = 1;
    write8(8'hA5);
    capture(0, 50);
    exp_len = 0; add_frame(9'h0A5, 8, 0, 2, 4); add_idle(2);
    for (int i = 0; i < exp_len; i++) begin
      total++;
      if (log_txd[i] !== exp_txd[i] || log_en[i] !== exp_en[i]) begin
        bad++; $display("FAIL par_even_cycle%0d got=txd%b/en%b want=txd%b/en%b", i, log_txd[i], log_en[i], exp_txd[i], exp_en[i]);
      end
    end
    // odd parity, one stop bit -> parity 1
    parity_odd = 1; two_stop = 0;
    write8(8'hA5);
    capture(0, 45);
    exp_len = 0; add_frame(9'h0A5, 8, 1, 1, 4); add_idle(1);
    for (int i = 0; i < exp_len; i++) begin
      total++;
      if (log_txd[i] !== exp_txd[i] || log_en[i] !== exp_en[i]) begin
        bad++; $display("FAIL par_odd_cycle%0d got=txd%b/en%b want=txd%b/en%b", i, log_txd[i], log_en[i], exp_txd[i], exp_en[i]);
      end
    end
    parity_en = 0; parity_odd = 0;
  endtask

  task automatic test_flow_control();
    do_reset();
    baud_div = 16'd1; cts = 0;
    tick(); tick(); tick();
    write8(8'h11); write8(8'h22); write8(8'h33);
    capture(0, 8);
    for (int i = 0; i < 8; i++) begin
      total++; if (log_txd[i] !== 1'b1) begin bad++; $display("FAIL flow_hold_txd%0d got=%b want=1", i, log_txd[i]); end
    end
    total++; if (lvl8 !== 3'd3) begin bad++; $display("FAIL flow_level got=%0d want=3", lvl8); end
    cts = 1;
    wait_start("flow_b2b");
    capture(1, 61);
    exp_len = 0;
    add_frame(9'h011, 8, -1, 1, 2); add_frame(9'h022, 8, -1, 1, 2); add_frame(9'h033, 8, -1, 1, 2);
    add_idle(2);
    for (int i = 0; i < exp_len; i++) begin
      total++;
      if (log_txd[i] !== exp_txd[i] || log_en[i] !== exp_en[i]) begin
        bad++; $display("FAIL flow_b2b_cycle%0d got=txd%b/en%b want=txd%b/en%b", i, log_txd[i], log_en[i], exp_txd[i], exp_en[i]);
      end
    end
  endtask

  task automatic test_cts_drop();
    do_reset();
    baud_div = 16'd1; cts = 0;
    tick(); tick(); tick();
    write8(8'h11); write8(8'h22); write8(8'h33);
    cts = 1;
    wait_start("cts_drop_f1");
    capture(1, 24);          // into frame 2
    cts = 0;
    capture(25, 25);         // rest of frame 2, then idle
    exp_len = 0;
    add_frame(9'h011, 8, -1, 1, 2); add_frame(9'h022, 8, -1, 1, 2); add_idle(10);
    for (int i = 0; i < exp_len; i++) begin
      total++;
      if (log_txd[i] !== exp_txd[i] || log_en[i] !== exp_en[i]) begin
        bad++; $display("FAIL ctsdrop_cycle%0d got=txd%b/en%b want=txd%b/en%b", i, log_txd[i], log_en[i], exp_txd[i], exp_en[i]);
      end
    end
    total++; if (lvl8 !== 3'd1) begin bad++; $display("FAIL ctsdrop_level got=%0d want=1", lvl8); end
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL ctsdrop_busy got=%b want=1", busy8); end
    cts = 1;
    wait_start("cts_drop_f3");
    capture(1, 20);
    exp_len = 0; add_frame(9'h033, 8, -1, 1, 2); add_idle(1);
    for (int i = 0; i < exp_len; i++) begin
      total++;
      if (log_txd[i] !== exp_txd[i] || log_en[i] !== exp_en[i]) begin
        bad++; $display("FAIL ctsdrop_f3_cycle%0d got=txd%b/en%b want=txd%b/en%b", i, log_txd[i], log_en[i], exp_txd[i], exp_en[i]);
      end
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    baud_div = 16'd0; cts = 0;
    tick(); tick(); tick();
    write8(8'h01); write8(8'h02); write8(8'h03);
    total++; if (w8.wr_ready !== 1'b1) begin bad++; $display("FAIL full_ready_at3 got=%b want=1", w8.wr_ready); end
    write8(8'h04);
    total++; if (w8.wr_ready !== 1'b0) begin bad++; $display("FAIL full_ready_at4 got=%b want=0", w8.wr_ready); end
    write8(8'h05);
    total++; if (lvl8 !== 3'd4) begin bad++; $display("FAIL full_level got=%0d want=4", lvl8); end
    cts = 1;
    wait_start("full_drain");
    capture(1, 49);
    exp_len = 0;
    add_frame(9'h001, 8, -1, 1, 1); add_frame(9'h002, 8, -1, 1, 1);
    add_frame(9'h003, 8, -1, 1, 1); add_frame(9'h004, 8, -1, 1, 1);
    add_idle(10);
    for (int i = 0; i < exp_len; i++) begin
      total++;
      if (log_txd[i] !== exp_txd[i] || log_en[i] !== exp_en[i]) begin
        bad++; $display("FAIL full_cycle%0d got=txd%b/en%b want=txd%b/en%b", i, log_txd[i], log_en[i], exp_txd[i], exp_en[i]);
      end
    end
    total++; if (busy8 !== 1'b0 || lvl8 !== 3'd0) begin bad++; $display("FAIL full_drained got=busy%b/lvl%0d want=busy0/lvl0", busy8, lvl8); end
  endtask

  task automatic test_div0_w9();
    do_reset();
    sel9 = 1'b1; baud_div9 = 16'd0; parity_en = 0; two_stop = 0; cts = 1;
    w9.wr_valid = 1'b1; w9.wr_data = 9'h1A5;
    tick();
    w9.wr_valid = 1'b0;
    capture(0, 13);
    exp_len = 0; add_frame(9'h1A5, 9, -1, 1, 1); add_idle(2);
    for (int i = 0; i < exp_len; i++) begin
      total++;
      if (log_txd[i] !== exp_txd[i] || log_en[i] !== exp_en[i]) begin
        bad++; $display("FAIL w9_cycle%0d got=txd%b/en%b want=txd%b/en%b", i, log_txd[i], log_en[i], exp_txd[i], exp_en[i]);
      end
    end
    sel9 = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    baud_div = 16'd3; cts = 1;
    write8(8'hA5); write8(8'h5A);
    for (int i = 0; i < 10; i++) tick();
    total++; if (lvl8 !== 3'd1 || tx_en8 !== 1'b1) begin bad++; $display("FAIL midrst_pre got=lvl%0d/en%b want=lvl1/en1", lvl8, tx_en8); end
    #2 HRESET = 1'b1;
    #1;
    total++; if (txd8 !== 1'b1)  begin bad++; $display("FAIL midrst_txd got=%b want=1", txd8); end
    total++; if (tx_en8 !== 1'b0) begin bad++; $display("FAIL midrst_tx_en got=%b want=0", tx_en8); end
    total++; if (lvl8 !== 3'd0)  begin bad++; $display("FAIL midrst_level got=%0d want=0", lvl8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy8); end
    total++; if (w8.wr_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", w8.wr_ready); end
    tick();
    HRESET = 1'b0;
    capture(0, 12);
    for (int i = 0; i < 12; i++) begin
      total++;
      if (log_txd[i] !== 1'b1 || log_en[i] !== 1'b0) begin
        bad++; $display("FAIL midrst_idle%0d got=txd%b/en%b want=txd1/en0", i, log_txd[i], log_en[i]);
      end
    end
  endtask

  initial begin
    HRESET = 1'b1;
    baud_div = 16'd3; baud_div9 = 16'd0;
    parity_en = 0; parity_odd = 0; two_stop = 0; cts = 1;
    w8.wr_valid = 0; w8.wr_data = '0;
    w9.wr_valid = 0; w9.wr_data = '0;
    test_reset();
    test_8n1();
    test_parity();
    test_flow_control();
    test_cts_drop();
    test_fifo_full();
    test_div0_w9();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
